// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types and constants.
// Fetch entry bundle carried from fetch to decode.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with async reset and sync flush.
// Ports: clk_i, rst_ni, flush_i, push_i, pop_i, wdata_i, rdata_o, count_o.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC register, imem address, prefetch FIFO.
// Ports: clk, rst(n), imem_*, redirect*, out_* handshake, queue_count.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_rd,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_pc_plus4,
  output logic [$clog2(DEPTH):0] queue_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] fetch_pc_d;
  logic            pop;
  logic            push;
  logic            fifo_pop;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign pop  = out_valid & out_ready;
  assign push = !redirect & ((queue_count != FULL_CNT) | pop);
  // A redirect discards the head rather than retiring it.
  assign fifo_pop = pop & !redirect;

  assign wr_entry.pc    = fetch_pc_q;
  assign wr_entry.instr = imem_rd;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    unique case (1'b1)
      redirect: fetch_pc_d = redirect_pc & ~32'h3;
      push:     fetch_pc_d = fetch_pc_q + STEP;
      default:  fetch_pc_d = fetch_pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fetch_pc_q <= RESET_PC;
    else      fetch_pc_q <= fetch_pc_d;
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (queue_count)
  );

  assign imem_addr = fetch_pc_q;
  assign out_valid = queue_count != '0;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  // With no head, show the next fetch PC + 4 (RESET_PC+4 out of reset).
  assign out_pc_plus4 = out_valid ? head.pc + STEP
                                  : fetch_pc_q + STEP;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 3-word imem model.
// Checks reset, streaming, backpressure, redirect, wrap, async reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [2:0]  queue_count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .queue_count  (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    imem_rd = 32'h0;
    case (imem_addr)
      32'h0:   imem_rd = 32'h0062_E233;
      32'h4:   imem_rd = 32'h00B6_2423;
      32'h8:   imem_rd = 32'h0000_0013;
      default: imem_rd = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;

    // Test 1: reset hold
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(queue_count), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc4", out_pc_plus4, 32'h4);
    rst = 1'b1;

    // Test 1/2: streaming with ready high
    step();
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t2_pc0", out_pc, 32'h0);
    chk("t2_in0", out_instr, 32'h0062_E233);
    chk("t2_p40", out_pc_plus4, 32'h4);
    step();
    chk("t2_pc1", out_pc, 32'h4);
    chk("t2_in1", out_instr, 32'h00B6_2423);
    chk("t2_p41", out_pc_plus4, 32'h8);
    step();
    chk("t2_pc2", out_pc, 32'h8);
    chk("t2_in2", out_instr, 32'h0000_0013);
    chk("t2_p42", out_pc_plus4, 32'hC);
    chk("t2_cnt", 32'(queue_count), 32'h1);

    // Test 3: backpressure fills to DEPTH
    out_ready = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3_fill", 32'(queue_count), 32'(i));
    end
    chk("t3_addr", imem_addr, 32'h10);
    step();
    chk("t3_hold_addr", imem_addr, 32'h10);
    chk("t3_hold_cnt", 32'(queue_count), 32'h4);
    chk("t3_hold_pc", out_pc, 32'h0);
    chk("t3_hold_in", out_instr, 32'h0062_E233);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_pop_pc", out_pc, 32'h4);
    chk("t3_pop_cnt", 32'(queue_count), 32'h4);
    chk("t3_pop_addr", imem_addr, 32'h14);

    // Test 4: redirect from half full, coincident with ready
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step();
    step();
    chk("t4_half", 32'(queue_count), 32'h2);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0007;
    out_ready = 1'b1;
    step();
    redirect = 1'b0;
    out_ready = 1'b0;
    chk("t4_cnt", 32'(queue_count), 32'h0);
    chk("t4_valid", 32'(out_valid), 32'h0);
    chk("t4_addr", imem_addr, 32'h4);
    step();
    chk("t4_v1", 32'(out_valid), 32'h1);
    chk("t4_pc", out_pc, 32'h4);
    chk("t4_in", out_instr, 32'h00B6_2423);
    chk("t4_cnt1", 32'(queue_count), 32'h1);

    // Test 5: PC wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    out_ready = 1'b1;
    step();
    redirect = 1'b0;
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t5_valid0", 32'(out_valid), 32'h0);
    step();
    chk("t5_pc", out_pc, 32'hFFFF_FFFC);
    chk("t5_p4", out_pc_plus4, 32'h0);
    chk("t5_in", out_instr, 32'h0);
    chk("t5_wrap", imem_addr, 32'h0);
    step();
    chk("t5_pc2", out_pc, 32'h0);
    chk("t5_in2", out_instr, 32'h0062_E233);

    // Test 6: async reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_cnt", 32'(queue_count), 32'h0);
    chk("t6_pc", out_pc, 32'h0);
    chk("t6_in", out_instr, 32'h0);
    chk("t6_addr", imem_addr, 32'h0);
    step();
    chk("t6_hold", 32'(out_valid), 32'h0);
    rst = 1'b1;
    step();
    chk("t6_rv", 32'(out_valid), 32'h1);
    chk("t6_rpc", out_pc, 32'h0);
    chk("t6_rin", out_instr, 32'h0062_E233);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
